queue_budget_reader: RTL

- Consumer-side controller for the single-clock RAM queue (valueIn/valueInValid/consumed/valueOut/empty/full).
- Pops entries from the queue and presents them on a registered valid/ready output stage.
- Issues are rate-limited by a MemorEDF-style budget: at most `budget` pops per `period` cycles.
- Sits between a queue instance and a downstream AXI-side issuer in the sink datapath.

---
 rtl/queue_reader_pkg.sv | 17 +
 rtl/queue_budget_reader_budget_timer.sv | 54 +++++
 rtl/queue_budget_reader.sv | 119 +++++++++++
 3 files changed

// File: rtl/queue_reader_pkg.sv
// Shared state type, reset policy and helper for the queue budget reader slice.
package queue_reader_pkg;

    typedef enum logic [1:0] {
        DISABLED,
        RUN,
        THROTTLED
    } state_t;

    // The budget timer reloads on the first clock after reset is released.
    localparam bit RELOAD_ON_RESET = 1'b1;

    function automatic logic [63:0] sat_dec(input logic [63:0] value, input logic dec);
        return (dec && (value != 64'd0)) ? value - 64'd1 : value;
    endfunction

endpackage

// File: rtl/queue_budget_reader_budget_timer.sv
// MemorEDF-style budget timer: hands out `budget` pop tokens per `period` cycles.
module budget_timer
    import queue_reader_pkg::*;
#(
    parameter int REGISTER_SIZE = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [REGISTER_SIZE-1:0] budget,
    input  logic [REGISTER_SIZE-1:0] period,
    input  logic                     consume,
    output logic                     tokens_ok,
    output logic                     reload,
    output logic                     exhausted
);

    logic [REGISTER_SIZE-1:0] periodCnt;
    logic [REGISTER_SIZE-1:0] tokens;
    logic [REGISTER_SIZE-1:0] tokensNext;
    logic                     primed;
    logic                     throttling;

    assign throttling = (period != '0);
    assign reload     = !primed || (throttling && (periodCnt >= period - REGISTER_SIZE'(1)));
    assign tokens_ok  = primed && (!throttling || (tokens != '0));
    assign exhausted  = throttling && (tokensNext == '0);

    // Leftover tokens are dropped at reload; a pop on the reload cycle is charged to the new window.
    always_comb begin
        tokensNext = tokens;
        if (reload) begin
            tokensNext = REGISTER_SIZE'(sat_dec(64'(budget), consume));
        end else if (throttling) begin
            tokensNext = REGISTER_SIZE'(sat_dec(64'(tokens), consume));
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            periodCnt <= '0;
            tokens    <= '0;
            primed    <= !RELOAD_ON_RESET;
        end else begin
            primed <= 1'b1;
            tokens <= tokensNext;
            if (reload) begin
                periodCnt <= '0;
            end else if (throttling) begin
                periodCnt <= periodCnt + REGISTER_SIZE'(1);
            end
        end
    end

endmodule

// File: rtl/queue_budget_reader.sv
// Budget-limited consumer for the RAM queue with a registered valid/ready output stage.
// Optional stall/throttle statistics counters are enabled by QUEUE_BUDGET_READER_STATS_EN.
module queue_budget_reader
    import queue_reader_pkg::*;
#(
    parameter int DATA_SIZE     = 8,
    parameter int REGISTER_SIZE = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [REGISTER_SIZE-1:0] budget,
    input  logic [REGISTER_SIZE-1:0] period,
    input  logic [DATA_SIZE-1:0]     queueValue,
    input  logic                     queueEmpty,
    output logic                     queueConsumed,
    output logic [DATA_SIZE-1:0]     valueOut,
    output logic                     valueOutValid,
    input  logic                     valueOutReady,
    output logic                     throttled,
    output logic [REGISTER_SIZE-1:0] issuedCount
`ifdef QUEUE_BUDGET_READER_STATS_EN
    ,
    output logic [REGISTER_SIZE-1:0] stallCount,
    output logic [REGISTER_SIZE-1:0] throttleCount
`endif
);

    state_t state;
    logic   tokensOk;
    logic   reload;
    logic   exhausted;
    logic   load;
    logic   handshake;

    budget_timer #(
        .REGISTER_SIZE(REGISTER_SIZE)
    ) budgetTimer (
        .clock    (clock),
        .reset    (reset),
        .budget   (budget),
        .period   (period),
        .consume  (load),
        .tokens_ok(tokensOk),
        .reload   (reload),
        .exhausted(exhausted)
    );

    // Pop whenever the stage is free or emptying this cycle, so transfers can run back-to-back.
    assign load          = enable && !queueEmpty && tokensOk && (!valueOutValid || valueOutReady);
    assign queueConsumed = load;
    assign handshake     = valueOutValid && valueOutReady;
    assign throttled     = (state == THROTTLED);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valueOut      <= '0;
            valueOutValid <= 1'b0;
            issuedCount   <= '0;
        end else begin
            if (load) begin
                valueOut      <= queueValue;
                valueOutValid <= 1'b1;
            end else if (handshake) begin
                valueOutValid <= 1'b0;
            end
            if (handshake) begin
                issuedCount <= issuedCount + REGISTER_SIZE'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= DISABLED;
        end else begin
            case (state)
                DISABLED: begin
                    if (enable) begin
                        state <= exhausted ? THROTTLED : RUN;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state <= DISABLED;
                    end else if (exhausted) begin
                        state <= THROTTLED;
                    end
                end
                THROTTLED: begin
                    if (!enable) begin
                        state <= DISABLED;
                    end else if (reload && !exhausted) begin
                        state <= RUN;
                    end
                end
                default: state <= DISABLED;
            endcase
        end
    end

`ifdef QUEUE_BUDGET_READER_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stallCount    <= '0;
            throttleCount <= '0;
        end else begin
            if (valueOutValid && !valueOutReady) begin
                stallCount <= stallCount + REGISTER_SIZE'(1);
            end
            if (state == THROTTLED) begin
                throttleCount <= throttleCount + REGISTER_SIZE'(1);
            end
        end
    end
`else
`endif

endmodule
